// File: rtl/ren_iss_dispatch_pkg.sv
// rtl/ren_iss_dispatch_pkg.sv - shared REN->ISS record layout and dispatch FSM encodings
package ren_iss_dispatch_pkg;
   localparam int RENISS_WIDTH = 151;
   localparam int BUF_LOG2     = 2;
   localparam int MEMREAD_BIT  = 39;
   localparam int MEMWRITE_BIT = 40;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      ACTIVE  = 2'd1,
      BLK_IQ  = 2'd2,
      BLK_LSQ = 2'd3
   } disp_state_t;

   // Loads and stores go to the LSQ; everything else goes to the IQ.
   function automatic logic is_mem(input logic [RENISS_WIDTH-1:0] rec);
      return rec[MEMREAD_BIT] | rec[MEMWRITE_BIT];
   endfunction
endpackage

// File: rtl/ren_iss_dispatch_if.sv
// rtl/ren_iss_dispatch_if.sv - rename input and IQ/LSQ push bundle of the dispatch stage
interface ren_iss_dispatch_if
   import ren_iss_dispatch_pkg::*;
   ();
   logic                    REN_valid_IN;
   logic [RENISS_WIDTH-1:0] REN_data_IN;
   logic                    REN_stall_OUT;
   logic                    IQ_full_IN;
   logic                    LSQ_full_IN;
   logic                    IQ_pushReq_OUT;
   logic [RENISS_WIDTH-1:0] IQ_pushData_OUT;
   logic                    LSQ_pushReq_OUT;
   logic [RENISS_WIDTH-1:0] LSQ_pushData_OUT;

   // master: rename and issue side; slave: the dispatch block
   modport master (
      output REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
      input  REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT, LSQ_pushReq_OUT, LSQ_pushData_OUT
   );
   modport slave (
      input  REN_valid_IN, REN_data_IN, IQ_full_IN, LSQ_full_IN,
      output REN_stall_OUT, IQ_pushReq_OUT, IQ_pushData_OUT, LSQ_pushReq_OUT, LSQ_pushData_OUT
   );
endinterface

// File: rtl/ren_iss_dispatch_fifo.sv
// rtl/ren_iss_dispatch_fifo.sv - in-order dispatch buffer with push/pop/flush and head read
module dispatch_fifo #(
   parameter int WIDTH = 151,
   parameter int LOG2  = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [LOG2:0]    count,
   output logic [LOG2:0]    count_next,
   output logic [WIDTH-1:0] head_data
);
   localparam int DEPTH = 1 << LOG2;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LOG2-1:0]  rd_ptr;
   logic [LOG2-1:0]  wr_ptr;

   assign count_next = flush ? '0 : count + (LOG2+1)'(push) - (LOG2+1)'(pop);
   assign head_data  = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge CLK) begin
      if (!RESET || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/ren_iss_dispatch.sv
// rtl/ren_iss_dispatch.sv - steers buffered renamed instructions to IQ or LSQ in order
// Optional DISPATCH_STATS_EN adds saturating push/blocked-cycle counters.
module ren_iss_dispatch
   import ren_iss_dispatch_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FREEZE,
   input  logic              FLUSH,
   ren_iss_dispatch_if.slave bus
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]       stat_iq_OUT,
   output logic [31:0]       stat_lsq_OUT,
   output logic [31:0]       stat_blk_OUT
`endif
);
   localparam int              DEPTH    = 1 << BUF_LOG2;
   localparam logic [BUF_LOG2:0] DEPTH_C  = (BUF_LOG2+1)'(DEPTH);
   localparam logic [BUF_LOG2:0] STALL_AT = (BUF_LOG2+1)'(DEPTH - 1);

   logic [BUF_LOG2:0]     count;
   logic [BUF_LOG2:0]     count_next;
   logic [RENISS_WIDTH-1:0] head;
   disp_state_t           state;
   logic                  stall_q;
   logic                  live;
   logic                  has_head;
   logic                  head_mem;
   logic                  iq_push;
   logic                  lsq_push;
   logic                  pop;
   logic                  accept;
   logic                  do_flush;

   // A flush or reset cycle never completes a push.
   always_comb begin
      live     = RESET && !FREEZE && !FLUSH;
      do_flush = RESET && !FREEZE && FLUSH;
      has_head = (count != '0);
      head_mem = is_mem(head);
      iq_push  = live && has_head && !head_mem && !bus.IQ_full_IN;
      lsq_push = live && has_head &&  head_mem && !bus.LSQ_full_IN;
      pop      = iq_push || lsq_push;
      accept   = live && bus.REN_valid_IN && (count < DEPTH_C);
   end

   dispatch_fifo #(
      .WIDTH (RENISS_WIDTH),
      .LOG2  (BUF_LOG2)
   ) u_fifo (
      .CLK        (CLK),
      .RESET      (RESET),
      .push       (accept),
      .pop        (pop),
      .flush      (do_flush),
      .wdata      (bus.REN_data_IN),
      .count      (count),
      .count_next (count_next),
      .head_data  (head)
   );

   assign bus.IQ_pushReq_OUT   = iq_push;
   assign bus.LSQ_pushReq_OUT  = lsq_push;
   assign bus.IQ_pushData_OUT  = head;
   assign bus.LSQ_pushData_OUT = head;
   assign bus.REN_stall_OUT    = stall_q;

   // Stall one slot early so the instruction rename sends while stall rises still fits.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state   <= EMPTY;
         stall_q <= 1'b0;
      end else if (!FREEZE) begin
         stall_q <= (count_next >= STALL_AT);
         if (count_next == '0) begin
            state <= EMPTY;
         end else begin
            case (state)
               EMPTY:   if (accept) state <= ACTIVE;
               ACTIVE: begin
                  if (has_head && head_mem && bus.LSQ_full_IN)
                     state <= BLK_LSQ;
                  else if (has_head && !head_mem && bus.IQ_full_IN)
                     state <= BLK_IQ;
               end
               BLK_IQ:  if (!bus.IQ_full_IN)  state <= ACTIVE;
               BLK_LSQ: if (!bus.LSQ_full_IN) state <= ACTIVE;
               default: state <= EMPTY;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET && !FREEZE && !FLUSH)
         assert (!(bus.REN_valid_IN && count == DEPTH_C))
            else $error("dispatch overflow: rename valid dropped while buffer full");
   end

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stat_iq_OUT  <= '0;
         stat_lsq_OUT <= '0;
         stat_blk_OUT <= '0;
      end else if (!FREEZE) begin
         if (iq_push && stat_iq_OUT != '1)   stat_iq_OUT  <= stat_iq_OUT + 32'd1;
         if (lsq_push && stat_lsq_OUT != '1) stat_lsq_OUT <= stat_lsq_OUT + 32'd1;
         if ((state == BLK_IQ || state == BLK_LSQ) && stat_blk_OUT != '1)
            stat_blk_OUT <= stat_blk_OUT + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_ren_iss_dispatch.sv
// tb/tb_ren_iss_dispatch.sv - directed and random checks of ren_iss_dispatch against a queue model
module tb_ren_iss_dispatch;
   import ren_iss_dispatch_pkg::*;

   typedef logic [RENISS_WIDTH-1:0] rec_t;

   logic CLK    = 1'b0;
   logic RESET  = 1'b0;
   logic FREEZE = 1'b0;
   logic FLUSH  = 1'b0;

   ren_iss_dispatch_if bus ();

`ifdef DISPATCH_STATS_EN
   logic [31:0] stat_iq;
   logic [31:0] stat_lsq;
   logic [31:0] stat_blk;
`endif

   ren_iss_dispatch dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .FREEZE (FREEZE),
      .FLUSH  (FLUSH),
      .bus    (bus)
`ifdef DISPATCH_STATS_EN
      ,
      .stat_iq_OUT  (stat_iq),
      .stat_lsq_OUT (stat_lsq),
      .stat_blk_OUT (stat_blk)
`endif
   );

   always #5 CLK = ~CLK;

   int   compared   = 0;
   int   mismatched = 0;
   rec_t q[$];
   logic m_stall   = 1'b0;
   logic stall_lag = 1'b0;
   int   m_iq_cnt  = 0;
   int   m_lsq_cnt = 0;
   rec_t zero_rec  = '0;

   task automatic check(input string tag, input rec_t obs, input rec_t exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // kind: 0 ALU, 1 load, 2 store
   function automatic rec_t mk(input int kind);
      logic [159:0] raw;
      rec_t r;
      raw = {$urandom, $urandom, $urandom, $urandom, $urandom};
      r = raw[RENISS_WIDTH-1:0];
      r[39] = (kind == 1);
      r[40] = (kind == 2);
      return r;
   endfunction

   // One clock: drive, compare at negedge against the queue model, advance the model.
   task automatic cycle(input logic v, input rec_t d, input logic iqf, input logic lsqf,
                        input logic frz, input logic fl);
      logic has, mem, e_iq, e_lsq, acc, live;
      rec_t hd;
      bus.REN_valid_IN = v;
      bus.REN_data_IN  = d;
      bus.IQ_full_IN   = iqf;
      bus.LSQ_full_IN  = lsqf;
      FREEZE = frz;
      FLUSH  = fl;
      @(negedge CLK);
      live  = !frz && !fl;
      has   = (q.size() > 0);
      hd    = has ? q[0] : '0;
      mem   = hd[39] || hd[40];
      e_iq  = live && has && !mem && !iqf;
      e_lsq = live && has &&  mem && !lsqf;
      check("iq_req",   rec_t'(bus.IQ_pushReq_OUT),  rec_t'(e_iq));
      check("lsq_req",  rec_t'(bus.LSQ_pushReq_OUT), rec_t'(e_lsq));
      check("both_req", rec_t'(bus.IQ_pushReq_OUT & bus.LSQ_pushReq_OUT), zero_rec);
      check("iq_data",  bus.IQ_pushData_OUT,  hd);
      check("lsq_data", bus.LSQ_pushData_OUT, hd);
      check("stall",    rec_t'(bus.REN_stall_OUT), rec_t'(m_stall));
      check("count",    rec_t'(dut.count), rec_t'(q.size()));
      stall_lag = m_stall;
      if (!frz) begin
         if (fl) begin
            q.delete();
            m_stall = 1'b0;
         end else begin
            acc = v && (q.size() < 4);
            if (e_iq)  begin void'(q.pop_front()); m_iq_cnt++;  end
            if (e_lsq) begin void'(q.pop_front()); m_lsq_cnt++; end
            if (acc) q.push_back(d);
            m_stall = (q.size() >= 3);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input logic iqf, input logic lsqf);
      cycle(1'b0, zero_rec, iqf, lsqf, 1'b0, 1'b0);
   endtask

   initial begin
      bus.REN_valid_IN = 1'b0;
      bus.REN_data_IN  = '0;
      bus.IQ_full_IN   = 1'b0;
      bus.LSQ_full_IN  = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      check("rst_state", rec_t'(dut.state), rec_t'(EMPTY));
      check("rst_count", rec_t'(dut.count), zero_rec);
      check("rst_stall", rec_t'(bus.REN_stall_OUT), zero_rec);
      check("rst_iq",    rec_t'(bus.IQ_pushReq_OUT), zero_rec);
      check("rst_lsq",   rec_t'(bus.LSQ_pushReq_OUT), zero_rec);

      // three ALU instructions
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(0), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) idle(1'b0, 1'b0);

      // ALU, load, store
      cycle(1'b1, mk(0), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, mk(1), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, mk(2), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) idle(1'b0, 1'b0);
      check("t2_state", rec_t'(dut.state), rec_t'(EMPTY));

      // blocked ALU head holds back a load behind it
      cycle(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, mk(1), 1'b1, 1'b0, 1'b0, 1'b0);
      check("t3_blk", rec_t'(dut.state), rec_t'(BLK_IQ));
      idle(1'b1, 1'b0);
      check("t3_hold", rec_t'(dut.state), rec_t'(BLK_IQ));
      idle(1'b0, 1'b0);
      check("t3_act", rec_t'(dut.state), rec_t'(ACTIVE));
      idle(1'b0, 1'b0);
      check("t3_empty", rec_t'(dut.state), rec_t'(EMPTY));

      // fill against both queues full; rename reacts to stall one cycle late
      for (int i = 0; i < 6; i++)
         cycle(!stall_lag, mk(0), 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4_count", rec_t'(dut.count), rec_t'(4));
      check("t4_stall", rec_t'(bus.REN_stall_OUT), rec_t'(1));
      check("t4_state", rec_t'(dut.state), rec_t'(BLK_IQ));

      // drain to three, then flush
      idle(1'b0, 1'b0);
      check("t5_pre", rec_t'(dut.count), rec_t'(3));
      cycle(1'b0, zero_rec, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_stall", rec_t'(bus.REN_stall_OUT), zero_rec);
      check("t5_state", rec_t'(dut.state), rec_t'(EMPTY));
      idle(1'b0, 1'b0);
      cycle(1'b1, mk(2), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) idle(1'b0, 1'b0);

      // freeze with two buffered
      cycle(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, mk(0), 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, mk(1), 1'b0, 1'b0, 1'b1, (i == 1));
         check("t6_state", rec_t'(dut.state), rec_t'(BLK_IQ));
      end
      repeat (3) idle(1'b0, 1'b0);
`ifdef DISPATCH_STATS_EN
      check("t6_stat_iq",  rec_t'(stat_iq),  rec_t'(m_iq_cnt));
      check("t6_stat_lsq", rec_t'(stat_lsq), rec_t'(m_lsq_cnt));
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(!stall_lag && ($urandom_range(3) != 0), mk($urandom_range(2)),
               ($urandom_range(2) == 0), ($urandom_range(2) == 0),
               ($urandom_range(15) == 0), ($urandom_range(39) == 0));
      end
      repeat (6) idle(1'b0, 1'b0);
      check("end_count", rec_t'(dut.count), zero_rec);
`ifdef DISPATCH_STATS_EN
      check("end_stat_iq",  rec_t'(stat_iq),  rec_t'(m_iq_cnt));
      check("end_stat_lsq", rec_t'(stat_lsq), rec_t'(m_lsq_cnt));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
